// File: rtl/vga_frame_capture_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_frame_capture_if
// Description : Capture-control handshake and capture-RAM write bus between
//               the frame capture block (master) and its RAM/controller side
//               (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_frame_capture_if #(
    parameter int ADDR_W = 19
) ();
    logic              iCapture_req;   // one-cycle pulse, arms a capture
    logic              oCapture_busy;  // armed or capturing
    logic              oCapture_done;  // one-cycle pulse, capture complete
    logic              oWr_en;         // capture RAM write strobe
    logic [ADDR_W-1:0] oWr_addr;       // y*H_ACTIVE+x
    logic [23:0]       oWr_data;       // {B,G,R}

    modport master (
        input  iCapture_req,
        output oCapture_busy, oCapture_done, oWr_en, oWr_addr, oWr_data
    );

    modport slave (
        output iCapture_req,
        input  oCapture_busy, oCapture_done, oWr_en, oWr_addr, oWr_data
    );
endinterface
`default_nettype wire

// File: rtl/vga_frame_capture.sv
`default_nettype none
// ============================================================================
// Module      : vga_frame_capture
// Description : Sink-side monitor for the VGA pixel stream. Rebuilds pixel
//               coordinates, checks frame geometry, computes a per-frame
//               checksum, latches a probe pixel and, on request, writes one
//               whole frame into a capture RAM in {B,G,R} layout.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_frame_capture #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 19
) (
    input  wire        iVGA_CLK,
    input  wire        iRST_n,
    input  wire        iHS,
    input  wire        iVS,
    input  wire        iBLANK_n,
    input  wire [7:0]  iB,
    input  wire [7:0]  iG,
    input  wire [7:0]  iR,
    input  wire [9:0]  iProbe_x,
    input  wire [9:0]  iProbe_y,
    output logic       oFrame_done,
    output logic       oFrame_ok,
    output logic [9:0] oLines,
    output logic [31:0] oChecksum,
    output logic [23:0] oProbe_bgr,
    output logic [15:0] oFrame_count,
    vga_frame_capture_if.master cap_bus
);

    typedef enum logic [0:0] {
        MON_WAIT_SYNC = 1'b0,
        MON_RUN       = 1'b1
    } mon_state_t;

    typedef enum logic [1:0] {
        CAP_IDLE    = 2'd0,
        CAP_ARMED   = 2'd1,
        CAP_CAPTURE = 2'd2
    } cap_state_t;

    localparam logic [9:0] H_LIM = 10'(H_ACTIVE);
    localparam logic [9:0] V_LIM = 10'(V_ACTIVE);
    localparam logic [9:0] C_SAT = 10'h3FF;

    mon_state_t        mon_q, mon_d;
    cap_state_t        cap_q, cap_d;
    logic              vs_prev_q;
    logic              blank_prev_q;
    logic [9:0]        x_q;
    logic [9:0]        y_q;
    logic [31:0]       chk_q;
    logic              err_q;
    logic [23:0]       shadow_q;

    logic              frame_done_q;
    logic              frame_ok_q;
    logic [9:0]        lines_q;
    logic [31:0]       checksum_q;
    logic [23:0]       probe_q;
    logic [15:0]       frame_count_q;
    logic              busy_q;
    logic              cap_done_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [23:0]       wr_data_q;

    logic              w_frame_end;
    logic              w_cap_done;
    logic              w_wr;

    // Horizontal sync carries no information this block needs.
    logic w_unused_hs;
    assign w_unused_hs = iHS;

    wire              w_vs_fall  = vs_prev_q & ~iVS;
    wire              w_line_end = blank_prev_q & ~iBLANK_n;
    // A pixel that coincides with the frame edge is discarded.
    wire              w_pixel    = (mon_q == MON_RUN) & iBLANK_n & ~w_vs_fall;
    wire              w_in_range = (x_q < H_LIM) && (y_q < V_LIM);
    wire [23:0]       w_bgr      = {iB, iG, iR};
    wire [ADDR_W-1:0] w_addr     = ADDR_W'(y_q) * ADDR_W'(H_ACTIVE) + ADDR_W'(x_q);
    wire              w_probe_hit = (x_q == iProbe_x) && (y_q == iProbe_y);

    // Monitor next state: leave WAIT_SYNC on the first frame edge; only
    // edges seen while running close a frame.
    always_comb begin
        mon_d       = mon_q;
        w_frame_end = 1'b0;
        if (w_vs_fall) begin
            mon_d       = MON_RUN;
            w_frame_end = (mon_q == MON_RUN);
        end
    end

    // Capture next state: arm on request, capture the frame after the next
    // edge, finish on the edge after that.
    always_comb begin
        cap_d      = cap_q;
        w_cap_done = 1'b0;
        w_wr       = 1'b0;
        case (cap_q)
            CAP_IDLE: begin
                if (cap_bus.iCapture_req) cap_d = CAP_ARMED;
            end
            CAP_ARMED: begin
                if (w_vs_fall) cap_d = CAP_CAPTURE;
            end
            CAP_CAPTURE: begin
                w_wr = w_pixel & w_in_range;
                if (w_vs_fall) begin
                    cap_d      = CAP_IDLE;
                    w_cap_done = 1'b1;
                end
            end
            default: cap_d = CAP_IDLE;
        endcase
    end

    // State registers and input edge history.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            mon_q        <= MON_WAIT_SYNC;
            cap_q        <= CAP_IDLE;
            vs_prev_q    <= 1'b0;
            blank_prev_q <= 1'b0;
        end else begin
            mon_q        <= mon_d;
            cap_q        <= cap_d;
            vs_prev_q    <= iVS;
            // The discarded pixel on a frame edge must not later look like
            // the end of a line in the new frame.
            blank_prev_q <= w_vs_fall ? 1'b0 : iBLANK_n;
        end
    end

    // Coordinate rebuild, geometry check, running checksum and probe.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            x_q      <= '0;
            y_q      <= '0;
            chk_q    <= '0;
            err_q    <= 1'b0;
            shadow_q <= '0;
        end else if (w_vs_fall) begin
            x_q      <= '0;
            y_q      <= '0;
            chk_q    <= '0;
            err_q    <= 1'b0;
            shadow_q <= '0;
        end else if (mon_q == MON_RUN) begin
            if (w_pixel) begin
                chk_q <= {chk_q[30:0], chk_q[31]} ^ {8'h00, w_bgr};
                x_q   <= (x_q == C_SAT) ? x_q : x_q + 10'd1;
                if (!w_in_range) err_q <= 1'b1;
                if (w_probe_hit) shadow_q <= w_bgr;
            end else if (w_line_end) begin
                if (x_q != H_LIM) err_q <= 1'b1;
                y_q <= (y_q == C_SAT) ? y_q : y_q + 10'd1;
                x_q <= '0;
            end
        end
    end

    // Per-frame report registers, loaded at each frame boundary.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            frame_done_q  <= 1'b0;
            frame_ok_q    <= 1'b0;
            lines_q       <= '0;
            checksum_q    <= '0;
            probe_q       <= '0;
            frame_count_q <= '0;
        end else begin
            frame_done_q <= w_frame_end;
            if (w_frame_end) begin
                frame_ok_q    <= ~err_q & (y_q == V_LIM) & ~iBLANK_n;
                lines_q       <= y_q;
                checksum_q    <= chk_q;
                probe_q       <= shadow_q;
                frame_count_q <= frame_count_q + 16'd1;
            end
        end
    end

    // Capture status and RAM write port registers.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            busy_q     <= 1'b0;
            cap_done_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            busy_q     <= (cap_d != CAP_IDLE);
            cap_done_q <= w_cap_done;
            wr_en_q    <= w_wr;
            if (w_wr) begin
                wr_addr_q <= w_addr;
                wr_data_q <= w_bgr;
            end
        end
    end

    assign oFrame_done           = frame_done_q;
    assign oFrame_ok             = frame_ok_q;
    assign oLines                = lines_q;
    assign oChecksum             = checksum_q;
    assign oProbe_bgr            = probe_q;
    assign oFrame_count          = frame_count_q;
    assign cap_bus.oCapture_busy = busy_q;
    assign cap_bus.oCapture_done = cap_done_q;
    assign cap_bus.oWr_en        = wr_en_q;
    assign cap_bus.oWr_addr      = wr_addr_q;
    assign cap_bus.oWr_data      = wr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_frame_capture.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_vga_frame_capture
// Description : Randomized scoreboard bench for vga_frame_capture on a
//               reduced 16x8 frame geometry.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_frame_capture;

    localparam int H  = 16;
    localparam int V  = 8;
    localparam int AW = 19;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hs = 1'b1;
    logic        vs = 1'b1;
    logic        blank_n = 1'b0;
    logic [7:0]  b = 8'h0, g = 8'h0, r = 8'h0;
    logic [9:0]  px = 10'd0, py = 10'd0;

    wire         frame_done;
    wire         frame_ok;
    wire [9:0]   lines;
    wire [31:0]  checksum;
    wire [23:0]  probe;
    wire [15:0]  fcount;

    vga_frame_capture_if #(.ADDR_W(AW)) cap_if ();

    vga_frame_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
        .iVGA_CLK     (clk),
        .iRST_n       (rst_n),
        .iHS          (hs),
        .iVS          (vs),
        .iBLANK_n     (blank_n),
        .iB           (b),
        .iG           (g),
        .iR           (r),
        .iProbe_x     (px),
        .iProbe_y     (py),
        .oFrame_done  (frame_done),
        .oFrame_ok    (frame_ok),
        .oLines       (lines),
        .oChecksum    (checksum),
        .oProbe_bgr   (probe),
        .oFrame_count (fcount),
        .cap_bus      (cap_if)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [23:0]   data;
    } wr_t;

    typedef struct packed {
        logic        ok;
        logic [9:0]  lines;
        logic [31:0] chk;
        logic [23:0] probe;
        logic [15:0] cnt;
        logic        cdone;
        logic        busy;
    } fr_t;

    wr_t wr_q[$];
    fr_t fr_q[$];
    int  total = 0;
    int  bad   = 0;

    // reference model state
    bit          run_m = 0;
    int          cap_m = 0;          // 0 idle, 1 armed, 2 capturing
    logic [15:0] cnt_m = 16'd0;
    logic [23:0] pix_m[$];
    int          lines_m = 0;
    bit          bad_m = 0;
    logic [23:0] probe_m = 24'h0;

    // stimulus knobs
    bit          g_zero = 0;
    int          g_fx = -1, g_fy = -1;
    logic [23:0] g_fcol = 24'h0;
    int          g_req_at = -1, g_rst_at = -1;
    int          g_odd_line = -1, g_odd_len = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        int k = n % 32;
        if (k == 0) return v;
        return (v << k) | (v >> (32 - k));
    endfunction

    task automatic clear_frame_model();
        pix_m.delete();
        lines_m = 0;
        bad_m   = 0;
        probe_m = 24'h0;
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_status"}, 64'({frame_ok, lines, checksum}), 64'd0);
        chk({nm, "_report"}, 64'({probe, fcount, frame_done, cap_if.oCapture_busy,
                                  cap_if.oCapture_done, cap_if.oWr_en}), 64'd0);
        chk({nm, "_wrbus"}, 64'({cap_if.oWr_addr, cap_if.oWr_data}), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        blank_n = 1'b0;
        cap_if.iCapture_req = 1'b0;
        #1;
        check_all_zero("async_reset");
        wr_q.delete();
        fr_q.delete();
        run_m = 0;
        cap_m = 0;
        cnt_m = 16'd0;
        clear_frame_model();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drive nl active lines; knobs select odd line length, forced pixel,
    // capture request and mid-frame reset.
    task automatic drive_lines(input int nl);
        int pcnt;
        int len;
        logic [23:0] c;
        pcnt = 0;
        chk("busy_at_frame_start", 64'(cap_if.oCapture_busy), 64'(cap_m != 0));
        for (int y = 0; y < nl; y++) begin
            len = (y == g_odd_line) ? g_odd_len : H;
            for (int x = 0; x < len; x++) begin
                c = g_zero ? 24'h0 : 24'($urandom);
                if (x == g_fx && y == g_fy) c = g_fcol;
                if (pcnt == g_rst_at) begin
                    do_reset();
                    return;
                end
                @(negedge clk);
                blank_n = 1'b1;
                {b, g, r} = c;
                cap_if.iCapture_req = (pcnt == g_req_at);
                if (pcnt == g_req_at && cap_m == 0) cap_m = 1;
                if (run_m) begin
                    pix_m.push_back(c);
                    if (x == int'(px) && y == int'(py)) probe_m = c;
                    if (cap_m == 2 && x < H && y < V)
                        wr_q.push_back({AW'(y * H + x), c});
                end
                pcnt++;
            end
            if (run_m) begin
                if (len != H) bad_m = 1;
                lines_m++;
            end
            repeat (3) begin
                @(negedge clk);
                blank_n = 1'b0;
                cap_if.iCapture_req = 1'b0;
            end
        end
        if (run_m && nl != V) bad_m = 1;
    endtask

    // Vertical sync; act=1 puts an active pixel on the falling-edge cycle.
    task automatic vsync(input bit act);
        fr_t e;
        logic [31:0] cs;
        int n;
        repeat (2) begin
            @(negedge clk);
            blank_n = 1'b0;
            vs = 1'b1;
        end
        @(negedge clk);
        vs = 1'b0;
        blank_n = act;
        {b, g, r} = 24'($urandom);
        if (run_m) begin
            n  = pix_m.size();
            cs = 32'h0;
            for (int i = 0; i < n; i++) cs = cs ^ rotl({8'h00, pix_m[i]}, n - 1 - i);
            cnt_m   = cnt_m + 16'd1;
            e.ok    = !bad_m && (lines_m == V) && !act;
            e.lines = 10'(lines_m);
            e.chk   = cs;
            e.probe = probe_m;
            e.cnt   = cnt_m;
            e.cdone = (cap_m == 2);
            if (cap_m == 2) cap_m = 0;
            else if (cap_m == 1) cap_m = 2;
            e.busy  = (cap_m != 0);
            fr_q.push_back(e);
        end else begin
            run_m = 1;
            if (cap_m == 1) cap_m = 2;
        end
        clear_frame_model();
        @(negedge clk);
        blank_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            vs = 1'b1;
        end
    endtask

    fr_t e_fr;
    wr_t e_wr;

    // Frame-report monitor.
    always @(posedge clk) begin
        #1;
        if (frame_done) begin
            if (fr_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL frame_unexpected: got oFrame_done=1 expected none at %0t", $time);
            end else begin
                e_fr = fr_q.pop_front();
                chk("frame_ok",     64'(frame_ok),              64'(e_fr.ok));
                chk("lines",        64'(lines),                 64'(e_fr.lines));
                chk("checksum",     64'(checksum),              64'(e_fr.chk));
                chk("probe_bgr",    64'(probe),                 64'(e_fr.probe));
                chk("frame_count",  64'(fcount),                64'(e_fr.cnt));
                chk("capture_done", 64'(cap_if.oCapture_done),  64'(e_fr.cdone));
                chk("busy_at_edge", 64'(cap_if.oCapture_busy),  64'(e_fr.busy));
            end
        end else if (cap_if.oCapture_done) begin
            total++;
            bad++;
            $display("FAIL capture_done_alone: got oCapture_done=1 expected 0 at %0t", $time);
        end
    end

    // RAM write monitor.
    always @(posedge clk) begin
        #1;
        if (cap_if.oWr_en) begin
            if (wr_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL write_unexpected: got addr %0d expected no write at %0t",
                         cap_if.oWr_addr, $time);
            end else begin
                e_wr = wr_q.pop_front();
                chk("wr_addr", 64'(cap_if.oWr_addr), 64'(e_wr.addr));
                chk("wr_data", 64'(cap_if.oWr_data), 64'(e_wr.data));
            end
        end
    end

    initial begin
        cap_if.iCapture_req = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        rst_n = 1'b1;

        // all-zero frames: first edge unreported, second reports frame 1
        g_zero = 1;
        vsync(0); drive_lines(V); vsync(0);
        // single 0000FF pixel at the origin of an otherwise zero frame
        g_fx = 0; g_fy = 0; g_fcol = 24'h0000FF;
        drive_lines(V); vsync(0);
        chk("single_pixel_checksum", 64'(checksum), 64'h8000007F);
        g_fx = -1; g_zero = 0;

        // short line, then clean frame
        g_odd_line = 3; g_odd_len = H - 1;
        drive_lines(V); vsync(0);
        g_odd_line = -1;
        drive_lines(V); vsync(0);

        // probe hit and probe miss
        px = 10'd5; py = 10'd2; g_fx = 5; g_fy = 2; g_fcol = 24'hABCDEF;
        drive_lines(V); vsync(0);
        g_fx = -1;
        px = 10'd700; py = 10'd0;
        drive_lines(V); vsync(0);
        px = 10'd3; py = 10'd4;

        // long line, extra line, missing line
        g_odd_line = 1; g_odd_len = H + 1;
        drive_lines(V); vsync(0);
        g_odd_line = -1;
        drive_lines(V + 1); vsync(0);
        drive_lines(V - 1); vsync(0);

        // frame edge during an active pixel, then clean frame
        drive_lines(V); vsync(1);
        drive_lines(V); vsync(0);

        // capture: request mid-frame, capture next frame (second request ignored)
        g_req_at = 20;
        drive_lines(V);
        vsync(0);
        px = 10'd5; py = 10'd2; g_fx = 5; g_fy = 2; g_fcol = 24'hABCDEF; g_req_at = 30;
        drive_lines(V);
        g_req_at = -1; g_fx = -1;
        vsync(0);
        drive_lines(V); vsync(0);

        // reset in the middle of a capture frame
        g_req_at = 10;
        drive_lines(V);
        g_req_at = -1;
        vsync(0);
        g_rst_at = 50;
        drive_lines(V);
        g_rst_at = -1;
        vsync(0); drive_lines(V); vsync(0); drive_lines(V); vsync(0);

        // capture works again after reset
        g_req_at = 5;
        drive_lines(V);
        g_req_at = -1;
        vsync(0); drive_lines(V); vsync(0);

        repeat (5) @(negedge clk);
        chk("frames_left",  64'(fr_q.size()), 64'd0);
        chk("writes_left",  64'(wr_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
